// File: rtl/prism_in_cond.sv
`default_nettype none
// ============================================================================
//  Module   : prism_in_cond
//  Purpose  : Input conditioner in front of the PRISM in_data port. Each raw
//             pad input is synchronised, optionally inverted and glitch
//             filtered, then edge-detected into sticky status bits that can
//             raise a masked level interrupt.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        : rising-edge clock for all state
//    rst_n      : asynchronous active-low reset
//    pins_in    : raw asynchronous pad inputs (WIDTH bits)
//    cfg_addr   : register select (0 CTRL, 1 EDGE, 2 LEVEL, 3 reserved)
//    cfg_wr     : single-cycle write strobe
//    cfg_wdata  : write data
//    cfg_rdata  : combinational read data for cfg_addr
//    cond_data  : registered conditioned levels
//    rise/fall  : one-cycle pulses on cond_data transitions
//    irq        : level interrupt, OR of masked sticky edge bits
//
//  CTRL layout: [7:0] invert, [15:8] filt_en, [23:16] irq_mask,
//               [27:24] FILT, [31:28] read as zero.
//  The CTRL fields are 8 bits wide, so WIDTH must lie in 1..8.
// ============================================================================
module prism_in_cond #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pins_in,
    input  logic [1:0]       cfg_addr,
    input  logic             cfg_wr,
    input  logic [31:0]      cfg_wdata,
    output logic [31:0]      cfg_rdata,
    output logic [WIDTH-1:0] cond_data,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             irq
);

    localparam logic [1:0] C_ADDR_CTRL  = 2'd0;
    localparam logic [1:0] C_ADDR_EDGE  = 2'd1;
    localparam logic [1:0] C_ADDR_LEVEL = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sync1_q,    sync1_d;
    logic [WIDTH-1:0] sync2_q,    sync2_d;
    logic [27:0]      ctrl_q,     ctrl_d;
    logic [WIDTH-1:0] cond_q,     cond_d;
    logic [3:0]       cnt_q [WIDTH];
    logic [3:0]       cnt_d [WIDTH];
    logic [WIDTH-1:0] cond_dly_q, cond_dly_d;
    logic [WIDTH-1:0] rise_q,     rise_d;
    logic [WIDTH-1:0] fall_q,     fall_d;
    logic [WIDTH-1:0] rise_st_q,  rise_st_d;
    logic [WIDTH-1:0] fall_st_q,  fall_st_d;

    // ------------------------------------------------------------------
    // CTRL field decode
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] invert;
    logic [WIDTH-1:0] filt_en;
    logic [WIDTH-1:0] irq_mask;
    logic [3:0]       filt;
    logic [WIDTH-1:0] pre;
    logic [2*WIDTH-1:0] edge_clr;

    assign invert   = ctrl_q[0  +: WIDTH];
    assign filt_en  = ctrl_q[8  +: WIDTH];
    assign irq_mask = ctrl_q[16 +: WIDTH];
    assign filt     = ctrl_q[27:24];

    // Top nibble of the write data has no storage behind it.
    logic unused_wdata;
    assign unused_wdata = ^cfg_wdata[31:28];

    // An invert change flips pre immediately, so it is filtered and
    // edge-detected exactly like a pad transition.
    assign pre = sync2_q ^ invert;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        sync1_d    = pins_in;
        sync2_d    = sync1_q;
        ctrl_d     = ctrl_q;
        cond_d     = cond_q;
        cnt_d      = cnt_q;
        cond_dly_d = cond_q;
        edge_clr   = '0;

        if (cfg_wr && (cfg_addr == C_ADDR_CTRL)) begin
            ctrl_d = cfg_wdata[27:0];
        end
        if (cfg_wr && (cfg_addr == C_ADDR_EDGE)) begin
            edge_clr = cfg_wdata[2*WIDTH-1:0];
        end

        // Glitch filter: cnt counts consecutive mismatch cycles that have
        // already been seen; the transition is taken on the (FILT+1)th.
        // The >= compare lets a FILT reduction mid-count fire at once.
        for (int i = 0; i < WIDTH; i++) begin
            if (!filt_en[i]) begin
                cond_d[i] = pre[i];
                cnt_d[i]  = 4'd0;
            end else if (pre[i] == cond_q[i]) begin
                cnt_d[i]  = 4'd0;
            end else if (cnt_q[i] >= filt) begin
                cond_d[i] = pre[i];
                cnt_d[i]  = 4'd0;
            end else if (cnt_q[i] != 4'hF) begin
                cnt_d[i]  = cnt_q[i] + 4'd1;
            end
        end

        // Pulses are registered one cycle after cond_data moves.
        rise_d = cond_q & ~cond_dly_q;
        fall_d = ~cond_q & cond_dly_q;

        // A pulse present this cycle wins over a same-cycle W1C.
        rise_st_d = (rise_st_q & ~edge_clr[WIDTH-1:0])       | rise_q;
        fall_st_d = (fall_st_q & ~edge_clr[2*WIDTH-1:WIDTH]) | fall_q;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            ctrl_q     <= '0;
            cond_q     <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= 4'd0;
            end
            cond_dly_q <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            rise_st_q  <= '0;
            fall_st_q  <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            ctrl_q     <= ctrl_d;
            cond_q     <= cond_d;
            cnt_q      <= cnt_d;
            cond_dly_q <= cond_dly_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            rise_st_q  <= rise_st_d;
            fall_st_q  <= fall_st_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cond_data = cond_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign irq       = |(irq_mask & (rise_st_q | fall_st_q));

    always_comb begin
        cfg_rdata = 32'd0;
        case (cfg_addr)
            C_ADDR_CTRL:  cfg_rdata = {4'd0, ctrl_q};
            C_ADDR_EDGE:  cfg_rdata = 32'({fall_st_q, rise_st_q});
            C_ADDR_LEVEL: cfg_rdata = 32'({sync2_q, cond_q});
            default:      cfg_rdata = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_prism_in_cond.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prism_in_cond
//  Purpose  : Self-checking bench for prism_in_cond. A cycle-level model
//             of the conditioning rules is compared with the DUT after every
//             clock edge; directed scenarios add hand-computed expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prism_in_cond;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] pins_in = '0;
    logic [1:0]   cfg_addr = '0;
    logic         cfg_wr = 1'b0;
    logic [31:0]  cfg_wdata = '0;
    logic [31:0]  cfg_rdata;
    logic [W-1:0] cond_data;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         irq;

    int checks = 0;
    int errors = 0;

    prism_in_cond #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pins_in   (pins_in),
        .cfg_addr  (cfg_addr),
        .cfg_wr    (cfg_wr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .cond_data (cond_data),
        .rise      (rise),
        .fall      (fall),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [W-1:0] m_s1, m_s2, m_cond;
    logic [W-1:0] m_rise, m_fall, m_pend_r, m_pend_f;
    logic [W-1:0] m_rst, m_fst;
    logic [27:0]  m_ctrl;
    int           m_run [W];

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_cond = '0;
        m_rise = '0; m_fall = '0; m_pend_r = '0; m_pend_f = '0;
        m_rst = '0; m_fst = '0; m_ctrl = '0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
    endtask

    // One rising edge: a filtered bit follows pre only after it has
    // disagreed with the output for more than FILT successive samples.
    task automatic model_edge();
        logic [W-1:0] pre, n_cond, rose, fell;
        logic [15:0]  clr;
        int           filt;
        pre    = m_s2 ^ m_ctrl[7:0];
        n_cond = m_cond;
        filt   = int'(m_ctrl[27:24]);
        for (int i = 0; i < W; i++) begin
            if (!m_ctrl[8+i]) begin
                n_cond[i] = pre[i];
                m_run[i]  = 0;
            end else if (pre[i] == m_cond[i]) begin
                m_run[i] = 0;
            end else begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] > filt) begin
                    n_cond[i] = pre[i];
                    m_run[i]  = 0;
                end
            end
        end
        rose = n_cond & ~m_cond;
        fell = ~n_cond & m_cond;
        clr  = (cfg_wr && cfg_addr == 2'd1) ? cfg_wdata[15:0] : 16'd0;
        m_rst    = (m_rst & ~clr[7:0])  | m_rise;
        m_fst    = (m_fst & ~clr[15:8]) | m_fall;
        m_rise   = m_pend_r;
        m_fall   = m_pend_f;
        m_pend_r = rose;
        m_pend_f = fell;
        m_cond   = n_cond;
        m_s2     = m_s1;
        m_s1     = pins_in;
        if (cfg_wr && cfg_addr == 2'd0) m_ctrl = cfg_wdata[27:0];
    endtask

    function automatic logic [31:0] m_rdata(input logic [1:0] a);
        case (a)
            2'd0:    return {4'd0, m_ctrl};
            2'd1:    return {16'd0, m_fst, m_rst};
            2'd2:    return {16'd0, m_s2, m_cond};
            default: return 32'd0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("cond_data", 32'(cond_data), 32'(m_cond));
        chk("rise",      32'(rise),      32'(m_rise));
        chk("fall",      32'(fall),      32'(m_fall));
        chk("irq",       32'(irq),       32'(|(m_ctrl[23:16] & (m_rst | m_fst))));
        chk("cfg_rdata", cfg_rdata,      m_rdata(cfg_addr));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        else       model_reset();
        #1;
        compare_all();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cfg_addr  = a;
        cfg_wr    = 1'b1;
        cfg_wdata = d;
        tick();
        cfg_wr    = 1'b0;
        cfg_wdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        #1;
        model_reset();
        compare_all();
        chk("rst_cond", 32'(cond_data), 32'h0);
        chk("rst_irq",  32'(irq),       32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Unfiltered rising edge on pin 0
        pins_in[0] = 1'b1;
        repeat (2) tick();
        chk("unf_cond_c2", 32'(cond_data), 32'h00);
        tick();
        chk("unf_cond_c3", 32'(cond_data), 32'h01);
        tick();
        chk("unf_rise_c4", 32'(rise), 32'h01);
        tick();
        chk("unf_rise_c5", 32'(rise), 32'h00);
        cfg_addr = 2'd1;
        #1;
        chk("unf_edge_reg", cfg_rdata, 32'h0000_0001);

        // Interrupt mask, W1C, and set-beats-clear
        wr(2'd0, 32'h0001_0000);
        chk("irq_set", 32'(irq), 32'h1);
        wr(2'd1, 32'h0000_0001);
        chk("irq_w1c", 32'(irq), 32'h0);
        pins_in[0] = 1'b0;
        repeat (6) tick();
        chk("irq_fall", 32'(irq), 32'h1);
        wr(2'd1, 32'h0000_0101);
        chk("irq_clr2", 32'(irq), 32'h0);
        pins_in[0] = 1'b1;
        repeat (4) tick();
        chk("pulse_now", 32'(rise), 32'h01);
        wr(2'd1, 32'h0000_0001);
        chk("w1c_vs_set", cfg_rdata, 32'h0000_0001);
        chk("w1c_vs_irq", 32'(irq), 32'h1);
        wr(2'd1, 32'h0000_FFFF);

        // Invert on a low pin produces a rising edge
        wr(2'd0, 32'h0001_0002);
        tick();
        chk("inv_cond", 32'(cond_data), 32'h03);
        repeat (2) tick();
        cfg_addr = 2'd1;
        #1;
        chk("inv_rise_st", cfg_rdata, 32'h0000_0002);
        chk("inv_irq",     32'(irq),  32'h0);
        wr(2'd1, 32'h0000_FFFF);

        // Filter FILT=5 on pin 2: 5-cycle glitch rejected, 6-cycle accepted
        wr(2'd0, 32'h0500_0402);
        pins_in[2] = 1'b1;
        repeat (5) tick();
        pins_in[2] = 1'b0;
        repeat (10) tick();
        chk("glitch_cond", 32'(cond_data), 32'h03);
        cfg_addr = 2'd1;
        #1;
        chk("glitch_edge", cfg_rdata, 32'h0);
        pins_in[2] = 1'b1;
        repeat (7) tick();
        chk("filt_c7", 32'(cond_data), 32'h03);
        tick();
        chk("filt_c8", 32'(cond_data), 32'h07);

        // FILT 10 -> 2 while the mismatch count is at 7
        wr(2'd0, 32'h0A00_0402);
        pins_in[2] = 1'b0;
        repeat (9) tick();
        wr(2'd0, 32'h0200_0402);
        chk("filtchg_hold", 32'(cond_data), 32'h07);
        tick();
        chk("filtchg_fire", 32'(cond_data), 32'h03);

        // Reset in the middle of a filter count
        wr(2'd0, 32'h0500_0402);
        pins_in[2] = 1'b1;
        repeat (4) tick();
        pins_in = 8'hFF;
        cfg_addr = 2'd0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("mrst_cond", 32'(cond_data), 32'h0);
        chk("mrst_rise", 32'(rise),      32'h0);
        chk("mrst_fall", 32'(fall),      32'h0);
        chk("mrst_irq",  32'(irq),       32'h0);
        chk("mrst_ctrl", cfg_rdata,      32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("rel_c2", 32'(cond_data), 32'h00);
        tick();
        chk("rel_c3", 32'(cond_data), 32'hFF);
        tick();
        chk("rel_rise", 32'(rise), 32'hFF);
        tick();
        cfg_addr = 2'd1;
        #1;
        chk("rel_edge", cfg_rdata, 32'h0000_00FF);
        cfg_addr = 2'd3;
        #1;
        chk("addr3", cfg_rdata, 32'h0);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prism_in_cond.md
PRISM_IN_COND -- requirements
Module: prism_in_cond

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the number of conditioned input pins.
REQ-002 SHALL have input clk, 1 bit, the rising-edge clock for all state.
REQ-003 SHALL have input rst_n, 1 bit, the asynchronous active-low reset.
REQ-004 SHALL have input pins_in, WIDTH bits, the raw asynchronous pad inputs.
REQ-005 SHALL have input cfg_addr, 2 bits, the register select.
REQ-006 SHALL have input cfg_wr, 1 bit, a single-cycle write strobe.
REQ-007 SHALL have input cfg_wdata, 32 bits, the write data.
REQ-008 SHALL have output cfg_rdata, 32 bits, combinational read data for cfg_addr.
REQ-009 SHALL have output cond_data, WIDTH bits, the registered conditioned levels that feed the PRISM in_data.
REQ-010 SHALL have output rise, WIDTH bits, one-cycle pulses on cond_data 0->1 transitions.
REQ-011 SHALL have output fall, WIDTH bits, one-cycle pulses on cond_data 1->0 transitions.
REQ-012 SHALL have output irq, 1 bit, the level interrupt request.

Function
REQ-013 SHALL pass each pins_in bit through a two-flop synchronizer; sync[i] is the second flop output.
REQ-014 SHALL decode the CTRL register (addr 0) as follows:
- invert[7:0] at bits [7:0];
- filt_en[7:0] at bits [15:8];
- irq_mask[7:0] at bits [23:16];
- FILT[3:0] at bits [27:24];
- bits [31:28] read 0.
REQ-015 SHALL form the pre-filter value pre[i] = sync[i] XOR invert[i] combinationally.
REQ-016 SHALL, when filt_en[i]=0, load cond_data[i] <= pre[i] every cycle and hold cnt[i] at 0, giving pins_in to cond_data latency of 3 cycles.
REQ-017 SHALL, when filt_en[i]=1, use a 4-bit cnt[i]:
- pre[i]==cond_data[i] -> cnt[i] <= 0;
- mismatch and cnt[i] >= FILT -> cond_data[i] <= pre[i], cnt[i] <= 0;
- otherwise cnt[i] <= cnt[i]+1.
REQ-018 SHALL therefore require FILT+1 consecutive mismatch cycles before a filtered transition; FILT=0 behaves as unfiltered; a filtered edge takes 3+FILT cycles to reach cond_data.
REQ-019 SHALL discard a mismatch run shorter than FILT+1 cycles with no change on cond_data.
REQ-020 SHALL, on a FILT change mid-count, keep cnt values and compare against the new FILT on the next cycle (>= comparison, no cnt overflow; cnt saturates at 15).
REQ-021 SHALL register rise[i]/fall[i] from the cond_data[i] transition so each pulse is high for exactly one cycle, one cycle after cond_data changes.
REQ-022 SHALL set sticky bits rise_st[i]/fall_st[i] on the corresponding pulse.
REQ-023 SHALL make the EDGE register (addr 1) read {fall_st, rise_st} in the low 2*WIDTH bits and clear bits written with 1 (W1C).
REQ-024 SHALL give set priority over a W1C clear in the same cycle.
REQ-025 SHALL make the LEVEL register (addr 2) read-only, returning {sync, cond_data} in the low 2*WIDTH bits; writes to it are ignored.
REQ-026 SHALL return 0 for addr 3 reads and ignore addr 3 writes.
REQ-027 SHALL drive irq = OR over i of irq_mask[i] & (rise_st[i] | fall_st[i]), combinationally from registered state.
REQ-028 SHALL let a CTRL write take effect on the following cycle; an invert change is treated as an input change and passes through the filter, producing edges.

Reset
REQ-029 SHALL asynchronously clear on rst_n=0: synchronizer flops, cond_data, cnt, rise, fall, sticky bits, and CTRL, leaving irq=0 and cond_data=0.
REQ-030 SHALL, when pins are high at reset release, raise cond_data 3 cycles later, after which rise pulses and rise_st sets.
REQ-031 SHALL abandon any count in progress when reset is asserted mid-filter.

Verification
REQ-032 SHALL cover: CTRL=0, pins_in[0] 0->1 -> cond_data[0]=1 at cycle 3, rise[0] pulse at cycle 4, EDGE=0x0001.
REQ-033 SHALL cover: filt_en[2]=1, FILT=5, 5-cycle high glitch on pin 2 -> cond_data[2] stays 0, no edge; 6-cycle high -> cond_data[2]=1 at cycle 8.
REQ-034 SHALL cover: invert[1]=1 written with pin 1 low -> cond_data[1]=1, rise_st[1]=1.
REQ-035 SHALL cover: irq_mask[0]=1, rise_st[0]=1 -> irq=1; W1C 0x0001 -> irq=0 next cycle; W1C coincident with a new rise pulse -> bit stays 1.
REQ-036 SHALL cover: FILT changed 10->2 while cnt=7 -> transition on the next mismatch cycle.
REQ-037 SHALL cover: rst_n pulsed mid-filter -> all outputs 0 immediately, counters 0.
